// File: rtl/pwm_to_servo_if.sv
// Signal bundle between a servo-style PWM source and the pwm_to_servo capture block.
// The master drives the PWM line; the slave (capture block) returns the decoded position.
interface pwm_to_servo_if;
  logic       pwm_in;
  logic [7:0] servo_out;
  logic       update;
  logic       valid;
  logic       lost;
  logic       sat;

  modport master (
    output pwm_in,
    input  servo_out, update, valid, lost, sat
  );

  modport slave (
    input  pwm_in,
    output servo_out, update, valid, lost, sat
  );
endinterface

// File: rtl/pwm_to_servo.sv
// Servo PWM capture: measures pulse high time in units of CLKS_PER_LSB cycles and flags signal loss.
// Optional input deglitch filter enabled by defining PWM_DEGLITCH_EN.
module pwm_to_servo #(
  parameter int CLKS_PER_LSB    = 1000,
  parameter int TIMEOUT_CYCLES  = 2000000,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  pwm_to_servo_if.slave bus
);

  localparam int DW = (CLKS_PER_LSB > 1) ? $clog2(CLKS_PER_LSB) : 1;
  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_LSB - 1);
  localparam logic [PW-1:0] PER_LIMIT = PW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] div_q, div_d;
  logic [8:0]    code_q, code_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    servo_q, servo_d;
  logic          update_q, update_d;
  logic          valid_q, valid_d;
  logic          lost_q, lost_d;
  logic          sat_q, sat_d;

  logic          cond;
  logic          rise, fall, rise_ok, timeout;
  logic [DW-1:0] div_base, div_step;
  logic [8:0]    code_base, code_step;
  logic          wrap;

  // The synchronizer resets low, so a line already high at reset release would
  // look like a rise; only accept rises once a real low sample has reached s2.
  always_comb begin
    s1_d    = bus.pwm_in;
    s2_d    = s1_q;
    s3_d    = cond;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);
  end

`ifdef PWM_DEGLITCH_EN
  localparam int GW = $clog2(DEGLITCH_CYCLES + 1);

  logic          filt_q, filt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  always_comb begin
    filt_d = filt_q;
    gcnt_d = '0;
    if (s2_q != filt_q) begin
      if (gcnt_q == GW'(DEGLITCH_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        gcnt_d = gcnt_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign cond = filt_q;
`else
  // The filter length has no role without the deglitch stage.
  logic unused_deglitch;
  assign unused_deglitch = (DEGLITCH_CYCLES > 0);
  assign cond = s2_q;
`endif

  assign rise    = cond & ~s3_q;
  assign fall    = ~cond & s3_q;
  assign rise_ok = rise & armed_q;
  assign timeout = (state_q != IDLE) && (per_q == PER_LIMIT);

  // One prescaler step; a rise restarts from zero and still counts its own cycle.
  always_comb begin
    div_base  = rise_ok ? '0 : div_q;
    code_base = rise_ok ? '0 : code_q;
    wrap      = (div_base == DIV_LAST);
    div_step  = wrap ? '0 : div_base + DW'(1);
    code_step = (wrap && !code_base[8]) ? code_base + 9'd1 : code_base;
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    div_d    = div_q;
    code_d   = code_q;
    per_d    = per_q;
    servo_d  = servo_q;
    update_d = 1'b0;
    valid_d  = valid_q;
    lost_d   = lost_q;
    sat_d    = sat_q;

    if (rise_ok) begin
      state_d = HIGH;
      per_d   = '0;
      div_d   = div_step;
      code_d  = code_step;
    end else if (timeout) begin
      state_d = IDLE;
      per_d   = '0;
      lost_d  = 1'b1;
      valid_d = 1'b0;
    end else if (state_q == HIGH && fall) begin
      state_d  = LOW;
      per_d    = per_q + PW'(1);
      servo_d  = code_q[8] ? 8'hFF : code_q[7:0];
      sat_d    = code_q[8];
      update_d = 1'b1;
      valid_d  = 1'b1;
      lost_d   = 1'b0;
    end else if (state_q != IDLE) begin
      per_d = per_q + PW'(1);
      if (state_q == HIGH) begin
        div_d  = div_step;
        code_d = code_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      fill_q   <= '0;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      div_q    <= '0;
      code_q   <= '0;
      per_q    <= '0;
      servo_q  <= '0;
      update_q <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      fill_q   <= fill_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      div_q    <= div_d;
      code_q   <= code_d;
      per_q    <= per_d;
      servo_q  <= servo_d;
      update_q <= update_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.servo_out = servo_q;
  assign bus.update    = update_q;
  assign bus.valid     = valid_q;
  assign bus.lost      = lost_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_pwm_to_servo.sv
// Directed bench for pwm_to_servo with scaled timing (10 clocks per LSB, 5000-cycle timeout).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pwm_to_servo;

  localparam int CLKS = 10;
  localparam int TOUT = 5000;
  localparam int DGL  = 4;
`ifdef PWM_DEGLITCH_EN
  localparam int LAT = 3 + DGL;
`else
  localparam int LAT = 3;
`endif

  localparam int       B_HIGH[5] = '{1, 2550, 2559, 2560, 3000};
  localparam int       B_CODE[5] = '{0, 255, 255, 255, 255};
  localparam bit [4:0] B_SAT     = 5'b11000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int         upd_cnt = 0;
  logic [7:0] last_code = '0;
  logic [7:0] prev_code = '0;
  bit         lost_seen = 1'b0;

  pwm_to_servo_if bus ();

  pwm_to_servo #(
    .CLKS_PER_LSB   (CLKS),
    .TIMEOUT_CYCLES (TOUT),
    .DEGLITCH_CYCLES(DGL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.update === 1'b1) begin
      upd_cnt   = upd_cnt + 1;
      prev_code = last_code;
      last_code = bus.servo_out;
    end
    if (bus.lost === 1'b1) lost_seen = 1'b1;
  end

  task automatic pulse(input int high_cycles, input int low_cycles);
    bus.pwm_in = 1'b1;
    repeat (high_cycles) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.servo_out !== 8'd0) begin errors++; $display("FAIL reset_servo: got %0d expected 0", bus.servo_out); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected 0", bus.update); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b expected 0", bus.lost); end
    checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", bus.sat); end
    rst = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (bus.valid !== 1'b0 || upd_cnt !== 0) begin errors++; $display("FAIL idle_after_reset: valid %b updates %0d expected 0 0", bus.valid, upd_cnt); end
  endtask

  task automatic test_nominal();
    int cnt0;
    pulse(1281, 2720);
    checks++; if (last_code !== 8'd128) begin errors++; $display("FAIL nominal_first: got %0d expected 128", last_code); end
    cnt0 = upd_cnt;
    bus.pwm_in = 1'b1;
    repeat (1281) @(negedge clk);
    bus.pwm_in = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL nominal_early_update: edge %0d got %b expected 0", i, bus.update); end
    end
    @(negedge clk);
    checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL nominal_latency: got update %b expected 1", bus.update); end
    checks++; if (bus.servo_out !== 8'd128) begin errors++; $display("FAIL nominal_servo: got %0d expected 128", bus.servo_out); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL nominal_valid: got %b expected 1", bus.valid); end
    checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL nominal_sat: got %b expected 0", bus.sat); end
    checks++; if (bus.lost !== 1'b0) begin errors++; $display("FAIL nominal_lost: got %b expected 0", bus.lost); end
    @(negedge clk);
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL nominal_strobe_width: got %b expected 0", bus.update); end
    repeat (2720 - LAT - 1) @(negedge clk);
    checks++; if (upd_cnt !== cnt0 + 1) begin errors++; $display("FAIL nominal_update_count: got %0d expected %0d", upd_cnt - cnt0, 1); end
  endtask

  task automatic test_bounds();
    int cnt0;
    for (int i = 0; i < 5; i++) begin
      cnt0 = upd_cnt;
      pulse(B_HIGH[i], 20);
`ifdef PWM_DEGLITCH_EN
      if (B_HIGH[i] < DGL) begin
        checks++; if (upd_cnt !== cnt0) begin errors++; $display("FAIL bounds_suppressed h=%0d: got %0d updates expected 0", B_HIGH[i], upd_cnt - cnt0); end
        continue;
      end
`endif
      checks++; if (upd_cnt !== cnt0 + 1) begin errors++; $display("FAIL bounds_update h=%0d: got %0d updates expected 1", B_HIGH[i], upd_cnt - cnt0); end
      checks++; if (bus.servo_out !== 8'(B_CODE[i])) begin errors++; $display("FAIL bounds_servo h=%0d: got %0d expected %0d", B_HIGH[i], bus.servo_out, B_CODE[i]); end
      checks++; if (bus.sat !== B_SAT[i]) begin errors++; $display("FAIL bounds_sat h=%0d: got %b expected %b", B_HIGH[i], bus.sat, B_SAT[i]); end
    end
  endtask

  task automatic test_loss();
    int cnt0;
    cnt0 = upd_cnt;
    pulse(500, 20);
    checks++; if (bus.servo_out !== 8'd50) begin errors++; $display("FAIL loss_setup: got %0d expected 50", bus.servo_out); end
    repeat (4000) @(negedge clk);
    checks++; if (bus.lost !== 1'b0 || bus.valid !== 1'b1) begin errors++; $display("FAIL loss_early: lost %b valid %b expected 0 1", bus.lost, bus.valid); end
    repeat (1000) @(negedge clk);
    checks++; if (bus.lost !== 1'b1) begin errors++; $display("FAIL loss_lost: got %b expected 1", bus.lost); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL loss_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.servo_out !== 8'd50) begin errors++; $display("FAIL loss_hold: got %0d expected 50", bus.servo_out); end
    checks++; if (upd_cnt !== cnt0 + 1) begin errors++; $display("FAIL loss_updates: got %0d expected 1", upd_cnt - cnt0); end
    pulse(770, 20);
    checks++; if (bus.lost !== 1'b0) begin errors++; $display("FAIL recover_lost: got %b expected 0", bus.lost); end
    checks++; if (bus.servo_out !== 8'd77 || bus.valid !== 1'b1) begin errors++; $display("FAIL recover_servo: got %0d valid %b expected 77 1", bus.servo_out, bus.valid); end
  endtask

  task automatic test_reset_mid_pulse();
    int cnt0;
    bus.pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.servo_out !== 8'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL async_reset: servo %0d valid %b expected 0 0", bus.servo_out, bus.valid); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cnt0 = upd_cnt;
    repeat (50) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (upd_cnt !== cnt0) begin errors++; $display("FAIL reset_discard: got %0d updates expected 0", upd_cnt - cnt0); end
    pulse(100, 20);
    checks++; if (upd_cnt !== cnt0 + 1 || bus.servo_out !== 8'd10) begin errors++; $display("FAIL after_reset_pulse: updates %0d servo %0d expected 1 10", upd_cnt - cnt0, bus.servo_out); end
  endtask

  task automatic test_timeout_race();
    int cnt0;
    // Rise-to-rise of TOUT+1 cycles lands the rise on the timeout cycle.
    pulse(100, 10);
    lost_seen = 1'b0;
    cnt0 = upd_cnt;
    repeat (TOUT + 1 - 110) @(negedge clk);
    pulse(100, 20);
    checks++; if (lost_seen !== 1'b0) begin errors++; $display("FAIL race_lost: got lost_seen %b expected 0", lost_seen); end
    checks++; if (upd_cnt !== cnt0 + 1 || bus.servo_out !== 8'd10) begin errors++; $display("FAIL race_measure: updates %0d servo %0d expected 1 10", upd_cnt - cnt0, bus.servo_out); end
    // One cycle later the timeout fires first.
    pulse(100, 10);
    lost_seen = 1'b0;
    repeat (TOUT + 2 - 110) @(negedge clk);
    pulse(100, 20);
    checks++; if (lost_seen !== 1'b1) begin errors++; $display("FAIL late_rise_lost: got lost_seen %b expected 1", lost_seen); end
    checks++; if (bus.lost !== 1'b0 || bus.servo_out !== 8'd10) begin errors++; $display("FAIL late_rise_recover: lost %b servo %0d expected 0 10", bus.lost, bus.servo_out); end
  endtask

  task automatic test_glitch();
    int cnt0;
    cnt0 = upd_cnt;
    bus.pwm_in = 1'b1;
    repeat (400) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (598) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (20) @(negedge clk);
`ifdef PWM_DEGLITCH_EN
    checks++; if (upd_cnt !== cnt0 + 1) begin errors++; $display("FAIL glitch_updates: got %0d expected 1", upd_cnt - cnt0); end
    checks++; if (last_code !== 8'd100) begin errors++; $display("FAIL glitch_code: got %0d expected 100", last_code); end
`else
    checks++; if (upd_cnt !== cnt0 + 2) begin errors++; $display("FAIL glitch_updates: got %0d expected 2", upd_cnt - cnt0); end
    checks++; if (prev_code !== 8'd40 || last_code !== 8'd59) begin errors++; $display("FAIL glitch_codes: got %0d,%0d expected 40,59", prev_code, last_code); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.pwm_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bounds();
    test_loss();
    test_reset_mid_pulse();
    test_timeout_race();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
